// File: rtl/as_pack.sv
// Shared types and constants for the GPIO output sequencer.
package as_pack;

  localparam int unsigned nr_gpios        = 8;
  localparam int unsigned gpio_addr_width = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StGap
  } gpio_state_e;

  typedef struct packed {
    logic [gpio_addr_width-1:0] addr;
    logic [nr_gpios-1:0]        data;
  } gpio_entry_t;

  // Status flag positions, counted upward from the top of the occupancy field
  localparam int unsigned StatEmptyOfs  = 0;
  localparam int unsigned StatFullOfs   = 1;
  localparam int unsigned StatBusyOfs   = 2;
  localparam int unsigned StatStickyOfs = 3;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/as_gpio_fifo.sv
// Queue of pending GPIO writes; occupancy counter 0..Depth, power-of-two pointer wrap.
module as_gpio_fifo
  import as_pack::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  gpio_entry_t     entry_i,
  input  logic            pop_i,
  output gpio_entry_t     entry_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  gpio_entry_t     mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign entry_o = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when the head leaves in the same cycle
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CntW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/as_gpio_out.sv
// Buffered GPIO output sequencer: queues bus writes and replays them as timed cs_o strobes.
// Optional status readback is enabled by defining AS_GPIO_STATUS_EN.
module as_gpio_out
  import as_pack::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CS_CYCLES  = 1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [gpio_addr_width-1:0] addr_i,
  input  logic [nr_gpios-1:0]        wdata_i,
  output logic                       ack_o,
  output logic [nr_gpios-1:0]        rdata_o,
  output logic [nr_gpios-1:0]        gpio_o,
  output logic [gpio_addr_width-1:0] gpioAddr_o,
  output logic                       cs_o
);

  localparam int unsigned CntW   = occ_width(FIFO_DEPTH);
  localparam int unsigned TmrMax = (CS_CYCLES > GAP_CYCLES) ? CS_CYCLES : GAP_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  gpio_state_e                state_q, state_d;
  logic [TmrW-1:0]            tmr_q, tmr_d;
  logic                       cs_q, cs_d;
  logic [nr_gpios-1:0]        gpio_q, gpio_d;
  logic [gpio_addr_width-1:0] addr_q, addr_d;

  logic            push, pop, start;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  gpio_entry_t     wr_entry, head;

  assign wr_entry.addr = addr_i;
  assign wr_entry.data = wdata_i;

  as_gpio_fifo #(
    .Depth (FIFO_DEPTH),
    .CntW  (CntW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .entry_i (wr_entry),
    .pop_i   (pop),
    .entry_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Reads never stall; writes stall only when full and the head is not leaving this cycle
  always_comb begin
    ack_o = 1'b0;
    if (!rst_i && req_i) begin
      ack_o = !we_i || !fifo_full || pop;
    end
  end

  assign push = req_i & we_i & ack_o;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cs_d    = cs_q;
    gpio_d  = gpio_q;
    addr_d  = addr_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        start = !fifo_empty;
      end
      StDrive: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TmrW'(1);
        end else if (GAP_CYCLES != 0) begin
          cs_d    = 1'b0;
          tmr_d   = TmrW'(GAP_CYCLES - 1);
          state_d = StGap;
        end else if (!fifo_empty) begin
          start = 1'b1;
        end else begin
          cs_d    = 1'b0;
          state_d = StIdle;
        end
      end
      StGap: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TmrW'(1);
        end else if (!fifo_empty) begin
          start = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (start) begin
      gpio_d  = head.data;
      addr_d  = head.addr;
      cs_d    = 1'b1;
      tmr_d   = TmrW'(CS_CYCLES - 1);
      state_d = StDrive;
    end
  end

  assign pop = start;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      cs_q    <= 1'b0;
      gpio_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cs_q    <= cs_d;
      gpio_q  <= gpio_d;
      addr_q  <= addr_d;
    end
  end

  assign cs_o       = cs_q;
  assign gpio_o     = gpio_q;
  assign gpioAddr_o = addr_q;

`ifdef AS_GPIO_STATUS_EN
  logic                sticky_bp_q;
  logic [nr_gpios-1:0] status;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_bp_q <= 1'b0;
    end else if (req_i && !we_i) begin
      sticky_bp_q <= 1'b0;
    end else if (req_i && we_i && !ack_o) begin
      sticky_bp_q <= 1'b1;
    end
  end

  always_comb begin
    status                       = '0;
    status[CntW-1:0]             = fifo_count;
    status[CntW + StatEmptyOfs]  = fifo_empty;
    status[CntW + StatFullOfs]   = fifo_full;
    status[CntW + StatBusyOfs]   = (state_q != StIdle);
    status[CntW + StatStickyOfs] = sticky_bp_q;
    rdata_o                      = '0;
    if (req_i && !we_i && ack_o) rdata_o = status;
  end
`else
  logic unused_count;
  assign unused_count = ^fifo_count;
  assign rdata_o      = '0;
`endif

endmodule
